// File: rtl/audio_sigma_delta_dac.sv
`timescale 1ns/1ps
// Audio output stage: sample-rate capture, pop-free gain ramp and first-order sigma-delta DAC.
// Optional macro AUDIO_DAC_RAMP_EN enables the gain ramp; without it gain switches 0/256 directly.
module audio_sigma_delta_dac #(
    parameter int SAMPLE_DIV       = 256,
    parameter int RAMP_STEP_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [8:0] i_sample,
    input  logic       i_mute,
    output logic       o_dac,
    output logic       o_sample_stb,
    output logic [1:0] o_state,
    output logic [8:0] o_gain
);
    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_e;

    localparam int               DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [8:0]       GAIN_MAX = 9'd256;

    logic [DIV_W-1:0] div_q, div_d;
    logic [8:0]       held_q, held_d;
    logic             stb_q, stb_d;
    state_e           state_q, state_d;
    logic [8:0]       gain;
    logic [17:0]      product;
    logic [8:0]       scaled_q, scaled_d;
    logic [9:0]       sum;
    logic [8:0]       acc_q, acc_d;
    logic             dac_q, dac_d;

    always_comb begin
        div_d  = div_q + 1'b1;
        held_d = held_q;
        stb_d  = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            held_d = i_sample;
            stb_d  = 1'b1;
        end
    end

`ifdef AUDIO_DAC_RAMP_EN
    localparam int                RCNT_W    = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RAMP_STEP_CYCLES - 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [8:0]        gain_q, gain_d;
    logic              step;

    // NOTE: gain_d is assigned before it is tested, so the end-of-ramp check sees this edge's step.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        step    = (rcnt_q == RCNT_LAST);
        rcnt_d  = step ? '0 : rcnt_q + 1'b1;
        unique case (state_q)
            MUTED: begin
                if (!i_mute) begin
                    state_d = RAMP_UP;
                    rcnt_d  = '0;
                end
            end
            RAMP_UP: begin
                if (i_mute) begin
                    state_d = RAMP_DOWN;
                    rcnt_d  = '0;
                end else begin
                    if (step && gain_q != GAIN_MAX) gain_d = gain_q + 1'b1;
                    if (gain_d == GAIN_MAX) begin
                        state_d = RUN;
                        rcnt_d  = '0;
                    end
                end
            end
            RUN: begin
                if (i_mute) begin
                    state_d = RAMP_DOWN;
                    rcnt_d  = '0;
                end
            end
            RAMP_DOWN: begin
                if (!i_mute) begin
                    state_d = RAMP_UP;
                    rcnt_d  = '0;
                end else begin
                    if (step && gain_q != 9'd0) gain_d = gain_q - 1'b1;
                    if (gain_d == 9'd0) begin
                        state_d = MUTED;
                        rcnt_d  = '0;
                    end
                end
            end
        endcase
    end

    assign gain = gain_q;
`else
    always_comb begin
        state_d = i_mute ? MUTED : RUN;
    end

    assign gain = (state_q == RUN) ? GAIN_MAX : 9'd0;
`endif

    // Gain 256 is unity: the >>8 returns held unchanged, and 511*256>>8 still fits 9 bits.
    assign product  = 18'(held_q) * 18'(gain);
    assign scaled_d = 9'(product >> 8);

    assign sum   = {1'b0, acc_q} + {1'b0, scaled_q};
    assign acc_d = sum[8:0];
    assign dac_d = sum[9];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_q    <= '0;
            held_q   <= '0;
            stb_q    <= 1'b0;
            state_q  <= MUTED;
            scaled_q <= '0;
            acc_q    <= '0;
            dac_q    <= 1'b0;
`ifdef AUDIO_DAC_RAMP_EN
            rcnt_q   <= '0;
            gain_q   <= '0;
`endif
        end else begin
            div_q    <= div_d;
            held_q   <= held_d;
            stb_q    <= stb_d;
            state_q  <= state_d;
            scaled_q <= scaled_d;
            acc_q    <= acc_d;
            dac_q    <= dac_d;
`ifdef AUDIO_DAC_RAMP_EN
            rcnt_q   <= rcnt_d;
            gain_q   <= gain_d;
`endif
        end
    end

    assign o_dac        = dac_q;
    assign o_sample_stb = stb_q;
    assign o_state      = state_q;
    assign o_gain       = gain;

endmodule

// File: tb/tb_audio_sigma_delta_dac.sv
`timescale 1ns/1ps
// Bench for audio_sigma_delta_dac: density vector table, directed ramp/mute/reset sequences and
// randomized stimulus against a cycle model. Expectations follow AUDIO_DAC_RAMP_EN when defined.
module tb_audio_sigma_delta_dac;
    localparam int SD  = 4;
    localparam int RSC = 1;
`ifdef AUDIO_DAC_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] smp;
    logic       mute;
    logic       o_dac;
    logic       o_sample_stb;
    logic [1:0] o_state;
    logic [8:0] o_gain;

    int checks   = 0;
    int failures = 0;
    int ones;
    int n;

    // Reference model state, plain integers; states numbered MUTED=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.
    int m_div, m_held, m_state, m_gain, m_rcnt, m_scaled, m_acc, m_dac, m_stb;

    typedef struct {
        int sample;
        int exp_ones;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    audio_sigma_delta_dac #(
        .SAMPLE_DIV      (SD),
        .RAMP_STEP_CYCLES(RSC)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_sample    (smp),
        .i_mute      (mute),
        .o_dac       (o_dac),
        .o_sample_stb(o_sample_stb),
        .o_state     (o_state),
        .o_gain      (o_gain)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input int s, input bit mt);
        int  total, n_state, n_gain, n_rcnt;
        bit  wrap;
        if (r) begin
            m_div = 0; m_held = 0; m_state = 0; m_gain = 0; m_rcnt = 0;
            m_scaled = 0; m_acc = 0; m_dac = 0; m_stb = 0;
            return;
        end
        total    = m_acc + m_scaled;
        m_dac    = (total >= 512) ? 1 : 0;
        m_acc    = total % 512;
        m_scaled = (m_held * m_gain) / 256;
        m_stb    = (m_div == SD - 1) ? 1 : 0;
        if (m_stb == 1) m_held = s;
        m_div = (m_div + 1) % SD;

        if (RAMP) begin
            n_state = m_state;
            n_gain  = m_gain;
            wrap    = (m_rcnt == RSC - 1);
            n_rcnt  = wrap ? 0 : m_rcnt + 1;
            if (mt && (m_state == 1 || m_state == 2)) begin
                n_state = 3; n_rcnt = 0;
            end else if (!mt && (m_state == 0 || m_state == 3)) begin
                n_state = 1; n_rcnt = 0;
            end else if (m_state == 1 || m_state == 3) begin
                if (wrap) begin
                    if (m_state == 1) n_gain = (m_gain < 256) ? m_gain + 1 : 256;
                    else              n_gain = (m_gain > 0)   ? m_gain - 1 : 0;
                end
                if (m_state == 1 && n_gain == 256) begin n_state = 2; n_rcnt = 0; end
                if (m_state == 3 && n_gain == 0)   begin n_state = 0; n_rcnt = 0; end
            end
            m_state = n_state;
            m_gain  = n_gain;
            m_rcnt  = n_rcnt;
        end else begin
            m_state = mt ? 0 : 2;
            m_gain  = mt ? 0 : 256;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, int'(smp), mute);
        #1;
        check("lockstep_dac",   int'(o_dac),        m_dac);
        check("lockstep_stb",   int'(o_sample_stb), m_stb);
        check("lockstep_state", int'(o_state),      m_state);
        check("lockstep_gain",  int'(o_gain),       m_gain);
    endtask

    task automatic count_ones(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            tick();
            cnt += int'(o_dac);
        end
    endtask

    task automatic wait_state(input int target, input int limit, input string name);
        int k = 0;
        while (int'(o_state) != target && k < limit) begin
            tick();
            k++;
        end
        check(name, int'(o_state), target);
    endtask

    initial begin
        vecs[0] = '{sample: 0,   exp_ones: 0};
        vecs[1] = '{sample: 511, exp_ones: 511};
        vecs[2] = '{sample: 1,   exp_ones: 1};
        vecs[3] = '{sample: 100, exp_ones: 100};
        vecs[4] = '{sample: 300, exp_ones: 300};
        vecs[5] = '{sample: 257, exp_ones: 257};

        rst  = 1'b1;
        smp  = 9'd0;
        mute = 1'b1;
        repeat (3) tick();
        check("reset_dac",   int'(o_dac),        0);
        check("reset_stb",   int'(o_sample_stb), 0);
        check("reset_state", int'(o_state),      0);
        check("reset_gain",  int'(o_gain),       0);

        // Release reset unmuted with a mid-scale sample.
        mute = 1'b0;
        smp  = 9'd256;
        rst  = 1'b0;
        tick();
`ifdef AUDIO_DAC_RAMP_EN
        check("s1_state_ramp_up", int'(o_state), 1);
        check("s1_gain_start",    int'(o_gain),  0);
        for (int k = 1; k <= 256; k++) begin
            tick();
            check("s1_gain_count", int'(o_gain), k);
        end
        check("s1_state_run", int'(o_state), 2);
`else
        check("s1_state_run", int'(o_state), 2);
        check("s1_gain_unity", int'(o_gain), 256);
`endif
        repeat (6) tick();
        count_ones(512, ones);
        check("s1_density_256", ones, 256);

        // Density table at unity gain.
        for (int i = 0; i < 6; i++) begin
            smp = 9'(vecs[i].sample);
            repeat (10) tick();
            count_ones(512, ones);
            check($sformatf("vec%0d_density_s%0d", i, vecs[i].sample), ones, vecs[i].exp_ones);
        end

        // Sample change one cycle after a strobe; strobe period.
        smp = 9'd100;
        repeat (8) tick();
        n = 0;
        while (!o_sample_stb && n < 8) begin
            tick();
            n++;
        end
        check("s3_stb_seen", int'(o_sample_stb), 1);
        n = 1;
        tick();
        smp = 9'd300;
        while (!o_sample_stb && n < 10) begin
            tick();
            n++;
        end
        check("s3_stb_period_a", n, SD);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_sample_stb && n < 10);
        check("s3_stb_period_b", n, SD);

        // Mute from RUN.
        smp = 9'd511;
        wait_state(2, 600, "s4_reach_run");
        repeat (10) tick();
        mute = 1'b1;
        tick();
`ifdef AUDIO_DAC_RAMP_EN
        check("s4_state_ramp_down", int'(o_state), 3);
        check("s4_gain_hold",       int'(o_gain),  256);
        for (int k = 255; k >= 0; k--) begin
            tick();
            check("s4_gain_fall", int'(o_gain), k);
        end
        check("s4_state_muted", int'(o_state), 0);
`else
        check("s4_state_muted", int'(o_state), 0);
        check("s4_gain_zero",   int'(o_gain),  0);
`endif
        repeat (2) tick();
        count_ones(64, ones);
        check("s4_dac_silent", ones, 0);

`ifdef AUDIO_DAC_RAMP_EN
        // Unmute mid ramp-down at gain 100.
        mute = 1'b0;
        wait_state(2, 600, "s5_reach_run");
        mute = 1'b1;
        n = 0;
        while (int'(o_gain) != 100 && n < 400) begin
            tick();
            n++;
        end
        check("s5_reach_100", int'(o_gain), 100);
        mute = 1'b0;
        tick();
        check("s5_state_ramp_up", int'(o_state), 1);
        check("s5_gain_100",      int'(o_gain),  100);
        tick();
        check("s5_gain_101", int'(o_gain), 101);
        tick();
        check("s5_gain_102", int'(o_gain), 102);
`else
        mute = 1'b0;
        tick();
        check("s5_direct_run", int'(o_state), 2);
        mute = 1'b1;
        tick();
        check("s5_direct_muted", int'(o_state), 0);
        mute = 1'b0;
`endif

        // Reset pulse mid-RUN.
        wait_state(2, 600, "s6_reach_run");
        rst = 1'b1;
        tick();
        check("s6_reset_dac",   int'(o_dac),        0);
        check("s6_reset_stb",   int'(o_sample_stb), 0);
        check("s6_reset_state", int'(o_state),      0);
        check("s6_reset_gain",  int'(o_gain),       0);
        rst = 1'b0;
        tick();
`ifdef AUDIO_DAC_RAMP_EN
        check("s6_restart_state", int'(o_state), 1);
        check("s6_restart_gain0", int'(o_gain),  0);
        tick();
        check("s6_restart_gain1", int'(o_gain),  1);
`else
        check("s6_restart_state", int'(o_state), 2);
        check("s6_restart_gain",  int'(o_gain),  256);
`endif

        // Randomized samples, mute toggles and rare resets against the model.
        for (int c = 0; c < 3000; c++) begin
            smp = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 149) == 0) mute = ~mute;
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
